// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into RV32I words and streams
// them into instruction memory through a registered word-write port.
// Optional feature macro: IMM_RANGE_CHECK_EN (reject unrepresentable immediates).
module instr_encoder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  finish,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            kind,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [31:0]           imm,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [31:0]           wdata,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  full,
    output logic                  err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    localparam logic [3:0] K_ADD  = 4'd0;
    localparam logic [3:0] K_SUB  = 4'd1;
    localparam logic [3:0] K_ADDI = 4'd2;
    localparam logic [3:0] K_LW   = 4'd3;
    localparam logic [3:0] K_LBU  = 4'd4;
    localparam logic [3:0] K_SB   = 4'd5;
    localparam logic [3:0] K_BEQ  = 4'd6;
    localparam logic [3:0] K_BNE  = 4'd7;
    localparam logic [3:0] K_JAL  = 4'd8;
    localparam logic [3:0] K_JALR = 4'd9;
    localparam logic [3:0] K_LUI  = 4'd10;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [ADDR_WIDTH-1:0] BASE_W  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP_W  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ONE_W   = ADDR_WIDTH'(1);

    logic [1:0]            state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic                  full_q, full_d;
    logic                  err_q, err_d;

    logic [31:0]           enc_word;
    logic                  kind_bad;
    logic                  imm_bad;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] count_inc;

    // Field packing per instruction format; illegal kinds fall back to NOP
    always_comb begin
        enc_word = NOP;
        kind_bad = 1'b0;
        case (kind)
            K_ADD:   enc_word = {7'b0000000, rs2, rs1, 3'b000, rd, OP_R};
            K_SUB:   enc_word = {7'b0100000, rs2, rs1, 3'b000, rd, OP_R};
            K_ADDI:  enc_word = {imm[11:0], rs1, 3'b000, rd, OP_IMM};
            K_LW:    enc_word = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
            K_LBU:   enc_word = {imm[11:0], rs1, 3'b100, rd, OP_LOAD};
            K_JALR:  enc_word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            K_SB:    enc_word = {imm[11:5], rs2, rs1, 3'b000, imm[4:0], OP_ST};
            K_BEQ:   enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000,
                                 imm[4:1], imm[11], OP_BR};
            K_BNE:   enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b001,
                                 imm[4:1], imm[11], OP_BR};
            K_JAL:   enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            K_LUI:   enc_word = {imm[31:12], rd, OP_LUI};
            default: kind_bad = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Flag immediates that the selected format cannot represent exactly
    always_comb begin
        imm_bad = 1'b0;
        case (kind)
            K_ADDI, K_LW, K_LBU, K_JALR, K_SB:
                imm_bad = !((imm[31:11] == '0) || (imm[31:11] == '1));
            K_BEQ, K_BNE:
                imm_bad = imm[0] || !((imm[31:12] == '0) || (imm[31:12] == '1));
            K_JAL:
                imm_bad = imm[0] || !((imm[31:20] == '0) || (imm[31:20] == '1));
            K_LUI:
                imm_bad = (imm[11:0] != '0);
            default:
                imm_bad = 1'b0;
        endcase
    end
`else
    // Immediates are truncated to the encoded bits, never rejected
    always_comb begin
        imm_bad = 1'b0;
    end
`endif

    assign in_ready  = (state_q == S_LOAD) && !start;
    assign accept    = in_valid && in_ready;
    assign count_inc = count_q + ONE_W;

    // Session control and write-port next state; start overrides everything else
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        ptr_d   = ptr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = err_q;
        if (start) begin
            state_d = S_LOAD;
            waddr_d = BASE_W;
            ptr_d   = BASE_W;
            count_d = '0;
            full_d  = 1'b0;
        end else begin
            if (accept) begin
                we_d    = 1'b1;
                waddr_d = ptr_q;
                ptr_d   = ptr_q + STEP_W;
                count_d = count_inc;
                if (kind_bad || imm_bad) begin
                    wdata_d = NOP;
                    err_d   = 1'b1;
                end else begin
                    wdata_d = enc_word;
                end
                if (count_inc == DEPTH_W) begin
                    full_d  = 1'b1;
                    state_d = S_FULL;
                end
            end
            if (finish && (state_q != S_IDLE)) begin
                state_d = S_IDLE;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            waddr_q <= BASE_W;
            ptr_q   <= BASE_W;
            wdata_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            ptr_q   <= ptr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign count = count_q;
    assign full  = full_q;
    assign err   = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a table of hand-encoded RV32I words plus
// short sequences for session control, depth limit and reset corner cases.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;

    logic        start_a, finish_a, in_valid_a, in_ready_a, we_a, full_a, err_a;
    logic [11:0] waddr_a, count_a;
    logic [31:0] wdata_a;

    logic        start_b, finish_b, in_valid_b, in_ready_b, we_b, full_b, err_b;
    logic [11:0] waddr_b, count_b;
    logic [31:0] wdata_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_WIDTH(12), .DEPTH(1024), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .finish(finish_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .we(we_a), .waddr(waddr_a), .wdata(wdata_a), .count(count_a),
        .full(full_a), .err(err_a)
    );

    instr_encoder #(.ADDR_WIDTH(12), .DEPTH(4), .BASE_ADDR(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .finish(finish_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .we(we_b), .waddr(waddr_b), .wdata(wdata_b), .count(count_b),
        .full(full_b), .err(err_b)
    );

    typedef struct {
        logic [3:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_word;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [3:0] k, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [31:0] im);
        kind = k; rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    initial begin
        vecs[0]  = '{4'd2,  5'd1,  5'd0,  5'd0,  32'd5,          32'h00500093, 1'b0};
        vecs[1]  = '{4'd1,  5'd3,  5'd1,  5'd2,  32'd0,          32'h402081B3, 1'b0};
        vecs[2]  = '{4'd7,  5'd0,  5'd1,  5'd0,  32'hFFFFFFFC,   32'hFE009EE3, 1'b0};
        vecs[3]  = '{4'd8,  5'd1,  5'd0,  5'd0,  32'd8,          32'h008000EF, 1'b0};
        vecs[4]  = '{4'd10, 5'd5,  5'd0,  5'd0,  32'h12345000,   32'h123452B7, 1'b0};
        vecs[5]  = '{4'd0,  5'd10, 5'd11, 5'd12, 32'd0,          32'h00C58533, 1'b0};
        vecs[6]  = '{4'd3,  5'd5,  5'd2,  5'd0,  32'd8,          32'h00812283, 1'b0};
        vecs[7]  = '{4'd4,  5'd6,  5'd10, 5'd0,  32'hFFFFFFFF,   32'hFFF54303, 1'b0};
        vecs[8]  = '{4'd5,  5'd31, 5'd2,  5'd5,  32'd12,         32'h00510623, 1'b0};
        vecs[9]  = '{4'd6,  5'd31, 5'd1,  5'd2,  32'd16,         32'h00208863, 1'b0};
        vecs[10] = '{4'd9,  5'd0,  5'd1,  5'd0,  32'd0,          32'h00008067, 1'b0};
        vecs[11] = '{4'd8,  5'd0,  5'd0,  5'd0,  32'hFFFFFFF8,   32'hFF9FF06F, 1'b0};
        vecs[12] = '{4'd2,  5'd1,  5'd0,  5'd31, 32'd5,          32'h00500093, 1'b0};
        vecs[13] = '{4'd15, 5'd1,  5'd2,  5'd3,  32'd5,          32'h00000013, 1'b1};

        rst = 1'b1;
        start_a = 1'b0; finish_a = 1'b0; in_valid_a = 1'b0;
        start_b = 1'b0; finish_b = 1'b0; in_valid_b = 1'b0;
        set_fields(4'd2, 5'd1, 5'd0, 5'd0, 32'd5);
        repeat (2) tick();

        // reset state
        check("rst_in_ready", 32'(in_ready_a), 32'd0);
        check("rst_we",       32'(we_a),       32'd0);
        check("rst_waddr",    32'(waddr_a),    32'd0);
        check("rst_wdata",    wdata_a,         32'd0);
        check("rst_count",    32'(count_a),    32'd0);
        check("rst_full",     32'(full_a),     32'd0);
        check("rst_err",      32'(err_a),      32'd0);
        rst = 1'b0;

        // IDLE ignores beats
        in_valid_a = 1'b1;
        tick();
        check("idle_we", 32'(we_a), 32'd0);
        check("idle_in_ready", 32'(in_ready_a), 32'd0);

        // start session
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        #1;
        check("start_in_ready", 32'(in_ready_a), 32'd1);
        check("start_count", 32'(count_a), 32'd0);

        // back-to-back table stream
        for (int i = 0; i < 14; i++) begin
            set_fields(vecs[i].kind, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            in_valid_a = 1'b1;
            tick();
            check($sformatf("vec%0d_we", i),    32'(we_a),    32'd1);
            check($sformatf("vec%0d_waddr", i), 32'(waddr_a), 32'(i * 4));
            check($sformatf("vec%0d_wdata", i), wdata_a,      vecs[i].exp_word);
            check($sformatf("vec%0d_count", i), 32'(count_a), 32'(i + 1));
            check($sformatf("vec%0d_err", i),   32'(err_a),   32'(vecs[i].exp_err));
        end
        in_valid_a = 1'b0;
        tick();
        check("gap_we", 32'(we_a), 32'd0);

        // start blocks in_ready, restarts address/count, keeps err
        start_a = 1'b1;
        #1;
        check("start_blocks_ready", 32'(in_ready_a), 32'd0);
        tick();
        start_a = 1'b0;
        check("restart_waddr", 32'(waddr_a), 32'd0);
        check("restart_count", 32'(count_a), 32'd0);
        check("err_sticky",    32'(err_a),   32'd1);

        // beat accepted together with finish still gets written
        set_fields(4'd2, 5'd1, 5'd0, 5'd0, 32'd5);
        in_valid_a = 1'b1;
        finish_a = 1'b1;
        tick();
        finish_a = 1'b0;
        check("fin_we",    32'(we_a),    32'd1);
        check("fin_wdata", wdata_a,      32'h00500093);
        check("fin_waddr", 32'(waddr_a), 32'd0);
        check("fin_count", 32'(count_a), 32'd1);
        #1;
        check("fin_in_ready", 32'(in_ready_a), 32'd0);
        tick();
        check("fin_no_write", 32'(we_a), 32'd0);

        // start and finish together: start wins
        in_valid_a = 1'b0;
        start_a = 1'b1;
        finish_a = 1'b1;
        tick();
        start_a = 1'b0;
        finish_a = 1'b0;
        #1;
        check("start_wins", 32'(in_ready_a), 32'd1);

        // reset mid-session with valid high
        in_valid_a = 1'b1;
        tick();
        check("pre_rst_we", 32'(we_a), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_we",    32'(we_a),    32'd0);
        check("midrst_count", 32'(count_a), 32'd0);
        check("midrst_err",   32'(err_a),   32'd0);
        check("midrst_waddr", 32'(waddr_a), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready_a), 32'd0);
        tick();
        check("postrst_we",       32'(we_a),       32'd0);
        check("postrst_in_ready", 32'(in_ready_a), 32'd0);
        check("postrst_count",    32'(count_a),    32'd0);

        // out-of-range ADDI immediate
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        set_fields(4'd2, 5'd1, 5'd0, 5'd0, 32'd4096);
        tick();
        in_valid_a = 1'b0;
        check("range_we", 32'(we_a), 32'd1);
`ifdef IMM_RANGE_CHECK_EN
        check("range_wdata", wdata_a,    32'h00000013);
        check("range_err",   32'(err_a), 32'd1);
`else
        check("range_wdata", wdata_a,    32'h00000093);
        check("range_err",   32'(err_a), 32'd0);
`endif

        // DEPTH=4 instance: four writes then FULL, fifth beat held
        set_fields(4'd2, 5'd1, 5'd0, 5'd0, 32'd5);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        in_valid_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("d4_we%0d", k),    32'(we_b),    32'd1);
            check($sformatf("d4_waddr%0d", k), 32'(waddr_b), 32'(k * 4));
            check($sformatf("d4_wdata%0d", k), wdata_b,      32'h00500093);
            check($sformatf("d4_count%0d", k), 32'(count_b), 32'(k + 1));
            check($sformatf("d4_full%0d", k),  32'(full_b),  32'(k == 3));
        end
        check("d4_in_ready_full", 32'(in_ready_b), 32'd0);
        tick();
        check("d4_held_we",    32'(we_b),    32'd0);
        check("d4_held_count", 32'(count_b), 32'd4);
        check("d4_held_full",  32'(full_b),  32'd1);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("d4_restart_waddr", 32'(waddr_b), 32'd0);
        check("d4_restart_count", 32'(count_b), 32'd0);
        check("d4_restart_full",  32'(full_b),  32'd0);
        tick();
        check("d4_resume_we",    32'(we_b),    32'd1);
        check("d4_resume_waddr", 32'(waddr_b), 32'd0);
        check("d4_resume_count", 32'(count_b), 32'd1);
        check("d4_err",          32'(err_b),   32'd0);
        in_valid_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
